// File: rtl/rf_alu_seq_pkg.sv
// Shared definitions for the RF_ALU micro-program sequencer.
package rf_alu_seq_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned PROG_AW    = 4;
  localparam int unsigned IMM_W      = 21;

  // Instruction kind, bits [31:30]
  typedef enum logic [1:0] {
    KIND_LOADI = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_HALT  = 2'b10,
    KIND_NOP   = 2'b11
  } kind_e;

  // ALU opcodes; forwarded to the ALU untouched
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StDone} state_e;

  // Field layout: [31:30] kind, [29:26] op, [25:21] wa, [20:16] ra, [15:11] rb
  typedef struct packed {
    kind_e       kind;
    logic [3:0]  op;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [10:0] rsvd;
  } instr_t;

  // LOADI immediate lives in [20:0] and overlaps ra/rb
  function automatic logic [31:0] simm(input logic [31:0] w);
    return {{(32 - IMM_W){w[IMM_W-1]}}, w[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/rf_alu_seq_if.sv
// Control/result bus between the sequencer and the RF_ALU datapath.
interface rf_alu_seq_if;
  logic        write_reg;
  logic        write_select;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic [4:0]  w_addr;
  logic [31:0] input_data;
  logic [3:0]  op;
  logic [31:0] alu_f;
  logic        zf;
  logic        cf;
  logic        of;
  logic        sf;
  logic        pf;

  modport master (
    output write_reg, write_select, r_addr_a, r_addr_b, w_addr, input_data, op,
    input  alu_f, zf, cf, of, sf, pf
  );

  modport slave (
    input  write_reg, write_select, r_addr_a, r_addr_b, w_addr, input_data, op,
    output alu_f, zf, cf, of, sf, pf
  );
endinterface

// File: rtl/rf_alu_seq_pmem.sv
// Program memory: synchronous write, asynchronous read registered into IR.
module rf_alu_seq_pmem
  import rf_alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = PROG_DEPTH,
  parameter int unsigned AW    = PROG_AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  input  logic          ir_load,
  output kind_e         fetch_kind,
  output logic [31:0]   ir
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata;

  // Program storage has no reset; contents survive Clr
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata      = mem[raddr];
  // FETCH needs the kind before IR is loaded to decide on HALT
  assign fetch_kind = kind_e'(rdata[31:30]);

  // Instruction register, loaded at the closing edge of FETCH
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)         ir <= '0;
    else if (ir_load) ir <= rdata;
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Micro-program sequencer driving the RF_ALU write/read/op controls.
module rf_alu_sequencer
  import rf_alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = PROG_DEPTH,
  parameter int unsigned AW    = PROG_AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
  rf_alu_seq_if.master  rf,
  output logic [31:0]   result,
  output logic [4:0]    flags,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] PcLast = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic          err_q;
  logic [31:0]   result_q;
  logic [4:0]    flags_q;
  logic [31:0]   ir_word;
  instr_t        ir;
  kind_e         fetch_kind;
  logic          accept;

  assign ir     = instr_t'(ir_word);
  assign accept = (state_q == StIdle) && start;

  rf_alu_seq_pmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pmem (
    .clk        (clk),
    .clr        (clr),
    .we         (prog_we && (state_q == StIdle)),
    .waddr      (prog_addr),
    .wdata      (prog_data),
    .raddr      (pc_q),
    .ir_load    (state_q == StFetch),
    .fetch_kind (fetch_kind),
    .ir         (ir_word)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = (fetch_kind == KIND_HALT) ? StDone : StExec;
      StExec:  state_d = (pc_q == PcLast) ? StIdle : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: fields always mirror IR, strobes only in EXEC
  always_comb begin
    rf.write_reg    = 1'b0;
    rf.write_select = 1'b0;
    rf.r_addr_a     = ir.ra;
    rf.r_addr_b     = ir.rb;
    rf.w_addr       = ir.wa;
    rf.op           = ir.op;
    rf.input_data   = simm(ir_word);
    if (state_q == StExec) begin
      rf.write_reg    = (ir.kind != KIND_NOP);
      rf.write_select = (ir.kind == KIND_LOADI);
    end
  end

  // PC, sticky error and ALU result capture
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q     <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        pc_q  <= '0;
        err_q <= 1'b0;
      end
      if (state_q == StExec) begin
        pc_q <= pc_q + 1'b1;
        if (pc_q == PcLast) err_q <= 1'b1;
        if (ir.kind == KIND_ALU) begin
          result_q <= rf.alu_f;
          flags_q  <= {rf.zf, rf.cf, rf.of, rf.sf, rf.pf};
        end
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign err    = err_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench: sequencer plus behavioural RF_ALU, scoreboard against a program interpreter.
module tb_rf_alu_sequencer;
  import rf_alu_seq_pkg::*;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        busy, done, err;

  rf_alu_seq_if rf ();

  rf_alu_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .rf        (rf.master),
    .result    (result),
    .flags     (flags),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural RF_ALU ----------------
  typedef struct packed {logic [31:0] f; logic [4:0] fl;} alu_r_t;

  function automatic alu_r_t alu_fn(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    alu_r_t r;
    logic [32:0] s;
    logic c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'b0100: begin
        s = {1'b0, a} + {1'b0, b};
        r.f = s[31:0];
        c = s[32];
        o = (a[31] == b[31]) && (r.f[31] != a[31]);
      end
      4'b0101: begin
        r.f = a - b;
        c = (a < b);
        o = (a[31] != b[31]) && (r.f[31] != a[31]);
      end
      4'b0001: r.f = a | b;
      4'b0010: r.f = a ^ b;
      4'b0111: r.f = a << b[4:0];
      default: r.f = 32'd0;
    endcase
    r.fl = {(r.f == 32'd0), c, o, r.f[31], ~^r.f};
    return r;
  endfunction

  logic [31:0] regs [32] = '{default: 32'd0};
  alu_r_t ar;
  always_comb ar = alu_fn(rf.op, regs[rf.r_addr_a], regs[rf.r_addr_b]);
  assign rf.alu_f = ar.f;
  assign {rf.zf, rf.cf, rf.of, rf.sf, rf.pf} = ar.fl;

  always @(posedge clk) begin
    if (rf.write_reg) regs[rf.w_addr] <= rf.write_select ? rf.input_data : rf.alu_f;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int ecount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {logic [4:0] wa; logic [31:0] data; logic sel;} wr_t;
  typedef struct {bit is_err; logic [31:0] res; logic [4:0] fl; int cyc; int start_e;} end_t;
  wr_t  wq[$];
  end_t eq[$];

  // Reference model: interprets the program word by word
  logic [31:0] m_prog [D];
  logic [31:0] m_regs [32] = '{default: 32'd0};
  logic [31:0] m_result = '0;
  logic [4:0]  m_flags = '0;

  task automatic model_run(input int start_e);
    int n;
    logic [31:0] w, v;
    alu_r_t r;
    end_t e;
    n = 0;
    for (int pc = 0; pc < D; pc++) begin
      w = m_prog[pc];
      if (w[31:30] == 2'b10) begin
        e = '{0, m_result, m_flags, 2 * n + 2, start_e};
        eq.push_back(e);
        return;
      end
      if (w[31:30] == 2'b00) begin
        v = {{11{w[20]}}, w[20:0]};
        wq.push_back('{w[25:21], v, 1'b1});
        m_regs[w[25:21]] = v;
      end else if (w[31:30] == 2'b01) begin
        r = alu_fn(w[29:26], m_regs[w[20:16]], m_regs[w[15:11]]);
        wq.push_back('{w[25:21], r.f, 1'b0});
        m_regs[w[25:21]] = r.f;
        m_result = r.f;
        m_flags = r.fl;
      end
      n++;
    end
    e = '{1, m_result, m_flags, 2 * D + 1, start_e};
    eq.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT writes or ends a run
  logic err_prev = 1'b0;
  logic post_done = 1'b0;
  wr_t  mw;
  end_t me;
  always @(negedge clk) begin
    if (clr) begin
      if (post_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (rf.write_reg) begin
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          mw = wq.pop_front();
          chk("w_addr", {27'd0, rf.w_addr}, {27'd0, mw.wa});
          chk("w_sel", {31'd0, rf.write_select}, {31'd0, mw.sel});
          chk("w_data", rf.write_select ? rf.input_data : rf.alu_f, mw.data);
        end
      end
      if (done || (err && !err_prev)) begin
        if (eq.size() == 0) chk("unexpected_end", 32'd1, 32'd0);
        else begin
          me = eq.pop_front();
          chk("end_is_err", {31'd0, err && !done}, {31'd0, me.is_err});
          chk("end_cycle", ecount - me.start_e, me.cyc);
          chk("result", result, me.res);
          chk("flags", {27'd0, flags}, {27'd0, me.fl});
        end
      end
    end
    err_prev  <= err;
    post_done <= done;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] li(input int wa, input logic [31:0] imm);
    logic [4:0] a;
    a = wa[4:0];
    return {2'b00, 4'd0, a, imm[20:0]};
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input int wa, input int ra,
                                      input int rb);
    logic [4:0] a, b, c;
    a = wa[4:0];
    b = ra[4:0];
    c = rb[4:0];
    return {2'b01, op, a, b, c, 11'd0};
  endfunction

  localparam logic [31:0] HALT = {2'b10, 30'd0};
  localparam logic [31:0] NOP  = {2'b11, 30'd0};

  task automatic load_word(input int a, input logic [31:0] w);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a[3:0];
    prog_data = w;
    m_prog[a] = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    foreach (p[i]) load_word(i, p[i]);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("run_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("eq_drained", eq.size(), 0);
  endtask

  // Start (optionally with a same-cycle program write) and wait for the end
  task automatic run_with(input bit do_wr, input int a, input logic [31:0] w);
    @(negedge clk);
    if (do_wr) begin
      m_prog[a] = w;
      prog_we = 1'b1;
      prog_addr = a[3:0];
      prog_data = w;
    end
    model_run(ecount);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b0;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    wait_idle();
  endtask

  task automatic run();
    run_with(0, 0, 32'd0);
  endtask

  logic [31:0] p[$];
  logic [3:0]  ops[5] = '{OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_SLL};

  initial begin
    foreach (m_prog[i]) m_prog[i] = HALT;
    #12;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_write_reg", {31'd0, rf.write_reg}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // 1: basic add
    p = '{li(1, 7), li(2, 4), alu(OP_ADD, 3, 1, 2), HALT};
    load_prog(p);
    run();
    chk("t1_result", result, 32'd11);
    chk("t1_zf", {31'd0, flags[4]}, 32'd0);

    // 2: subtracts, last one zero
    p = '{li(1, 7), li(2, 4), alu(OP_ADD, 3, 1, 2), alu(OP_SUB, 4, 1, 2),
          alu(OP_SUB, 5, 1, 1), HALT};
    load_prog(p);
    run();
    chk("t2_result", result, 32'd0);
    chk("t2_zf", {31'd0, flags[4]}, 32'd1);

    // 3: logic ops and shift
    load_word(2, alu(OP_OR, 6, 1, 2));
    load_word(3, HALT);
    run();
    chk("t3_or", result, 32'd7);
    load_word(2, alu(OP_XOR, 6, 1, 2));
    run();
    chk("t3_xor", result, 32'd3);
    load_word(2, alu(OP_SLL, 6, 1, 2));
    run();
    chk("t3_sll", result, 32'd112);

    // Same-cycle write and start: new word 2 must be seen
    run_with(1, 2, alu(OP_ADD, 6, 1, 2));
    chk("wr_start_same", result, 32'd11);

    // Random programs
    for (int k = 0; k < 25; k++) begin
      int len;
      len = $urandom_range(1, 14);
      p.delete();
      for (int i = 0; i < len; i++) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 40) p.push_back(li($urandom_range(0, 7), $urandom));
        else if (sel < 85)
          p.push_back(alu(ops[$urandom_range(0, 4)], $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7)));
        else p.push_back(NOP);
      end
      p.push_back(HALT);
      load_prog(p);
      run();
    end

    // 4: no HALT -> Err, then cleared by the next start
    for (int i = 0; i < D; i++) load_word(i, NOP);
    run();
    chk("t4_err", {31'd0, err}, 32'd1);
    p = '{li(1, 7), li(2, 4), alu(OP_ADD, 3, 1, 2), alu(OP_SUB, 4, 1, 2),
          alu(OP_SUB, 5, 1, 1), HALT};
    load_prog(p);
    run();
    chk("t4_err_clear", {31'd0, err}, 32'd0);

    // 6: Start and Prog_We while busy are ignored
    @(negedge clk);
    model_run(ecount);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = HALT;
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b0;
    wait_idle();
    run();
    chk("t6_result", result, 32'd0);

    // 5: async reset mid-EXEC, then rerun
    @(negedge clk);
    model_run(ecount);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int seen, t;
      seen = 0;
      t = 0;
      while (seen < 3 && t < 100) begin
        @(negedge clk);
        t++;
        if (rf.write_reg) seen++;
      end
      chk("t5_reached_exec", seen, 3);
    end
    #2 clr = 1'b0;
    #1;
    chk("t5_write_reg", {31'd0, rf.write_reg}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_result", result, 32'd0);
    wq.delete();
    eq.delete();
    m_result = '0;
    m_flags = '0;
    @(negedge clk);
    clr = 1'b1;
    run();
    chk("t5_rerun", result, 32'd0);
    chk("t5_rerun_zf", {31'd0, flags[4]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
